// File: rtl/ahb_lite_sram_slave.sv
// AHB-Lite slave in front of a register-array SRAM with byte-lane writes,
// a fixed number of wait states per beat and a two-cycle ERROR response.
module ahb_lite_sram_slave #(
  parameter int                DATA_W      = 32,
  parameter int                ADDR_W      = 32,
  parameter int                DEPTH       = 1024,
  parameter int                WAIT_STATES = 0,
  parameter logic [ADDR_W-1:0] BASE_ADDR   = '0
) (
  input  logic              i_hclk,
  input  logic              i_hrst,
  input  logic              i_hsel,
  input  logic [ADDR_W-1:0] i_haddr,
  input  logic [1:0]        i_htrans,
  input  logic [2:0]        i_hsize,
  input  logic [2:0]        i_hburst,
  input  logic              i_hwrite,
  input  logic              i_hready,
  input  logic [DATA_W-1:0] i_hwdata,
  output logic [DATA_W-1:0] o_hrdata,
  output logic              o_hreadyout,
  output logic [1:0]        o_hresp
);
  localparam int NB    = DATA_W / 8;
  localparam int OFF_W = $clog2(NB);
  localparam int IDX_W = $clog2(DEPTH);
  localparam logic [ADDR_W:0] WIN_BYTES = (ADDR_W+1)'(DEPTH * NB);
  localparam logic [3:0] WS_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_ERR1 = 2'd2;
  localparam logic [1:0] S_ERR2 = 2'd3;

  logic [1:0]        r_state;
  logic [3:0]        r_cnt;
  logic              r_active;
  logic              r_write;
  logic [IDX_W-1:0]  r_idx;
  logic [OFF_W-1:0]  r_lane;
  logic [2:0]        r_size;
  logic [DATA_W-1:0] r_mem [DEPTH];

  logic              w_ready;
  logic              w_accept;
  logic              w_bad;
  logic              w_commit;
  logic [ADDR_W-1:0] w_off;
  logic [OFF_W-1:0]  w_align_mask;
  logic [NB-1:0]     w_be;
  logic              w_unused;

  assign w_unused = ^{i_hburst, i_htrans[0]};

  assign w_ready  = (r_state == S_IDLE) || (r_state == S_ERR2);
  assign w_accept = i_hsel & i_hready & i_htrans[1] & w_ready;
  assign w_off    = i_haddr - BASE_ADDR;

  always_comb begin
    w_align_mask = '0;
    for (int i = 0; i < OFF_W; i++) w_align_mask[i] = (i < int'(i_hsize));
  end

  // Oversize, misaligned, or outside the window (no wrap past the top).
  assign w_bad = (int'(i_hsize) > OFF_W)
              || (|(i_haddr[OFF_W-1:0] & w_align_mask))
              || (i_haddr < BASE_ADDR)
              || ({1'b0, w_off} >= WIN_BYTES);

  always_ff @(posedge i_hclk or posedge i_hrst) begin
    if (i_hrst) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_active <= 1'b0;
      r_write  <= 1'b0;
      r_idx    <= '0;
      r_lane   <= '0;
      r_size   <= '0;
    end else begin
      case (r_state)
        S_WAIT: begin
          if (r_cnt == 4'd0) r_state <= S_IDLE;
          else               r_cnt   <= r_cnt - 4'd1;
        end
        S_ERR1: r_state <= S_ERR2;
        default: begin
          r_active <= w_accept & ~w_bad;
          if (w_accept) begin
            r_write <= i_hwrite;
            r_idx   <= w_off[OFF_W +: IDX_W];
            r_lane  <= w_off[OFF_W-1:0];
            r_size  <= i_hsize;
            if (w_bad) begin
              r_state <= S_ERR1;
            end else if (WAIT_STATES > 0) begin
              r_state <= S_WAIT;
              r_cnt   <= WS_LOAD;
            end else begin
              r_state <= S_IDLE;
            end
          end else begin
            r_state <= S_IDLE;
          end
        end
      endcase
    end
  end

  always_comb begin
    w_be = '0;
    for (int b = 0; b < NB; b++)
      w_be[b] = (b >= int'(r_lane)) && (b < int'(r_lane) + (1 << r_size));
  end

  // Good data phases only ever complete in IDLE.
  assign w_commit = r_active & r_write & (r_state == S_IDLE);

  always_ff @(posedge i_hclk) begin
    if (w_commit) begin
      for (int b = 0; b < NB; b++)
        if (w_be[b]) r_mem[r_idx][8*b +: 8] <= i_hwdata[8*b +: 8];
    end
  end

  assign o_hrdata    = (r_active && !r_write) ? r_mem[r_idx] : '0;
  assign o_hreadyout = w_ready;
  assign o_hresp     = ((r_state == S_ERR1) || (r_state == S_ERR2)) ? 2'b01 : 2'b00;

endmodule

// File: tb/tb_ahb_lite_sram_slave.sv
// Directed bench for ahb_lite_sram_slave: four instances sharing one bus,
// each selected individually, covering WS=0/2/3 and a 64-bit 16-word array.
module tb_ahb_lite_sram_slave;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [1:0] T_IDLE   = 2'b00;
  localparam logic [1:0] T_NONSEQ = 2'b10;
  localparam logic [1:0] T_SEQ    = 2'b11;

  logic        rst;
  logic [3:0]  sel;
  logic [31:0] haddr;
  logic [1:0]  htrans;
  logic [2:0]  hsize;
  logic [2:0]  hburst;
  logic        hwrite;
  logic [63:0] hwdata;

  logic [31:0] rd0, rd1, rd2;
  logic [63:0] rd3;
  logic        rdy0, rdy1, rdy2, rdy3;
  logic [1:0]  rsp0, rsp1, rsp2, rsp3;

  int n_assert = 0;
  int n_fail   = 0;

  ahb_lite_sram_slave #(.DATA_W(32), .ADDR_W(32), .DEPTH(1024), .WAIT_STATES(0), .BASE_ADDR(32'h0)) u0 (
    .i_hclk(clk), .i_hrst(rst), .i_hsel(sel[0]), .i_haddr(haddr), .i_htrans(htrans),
    .i_hsize(hsize), .i_hburst(hburst), .i_hwrite(hwrite), .i_hready(rdy0),
    .i_hwdata(hwdata[31:0]), .o_hrdata(rd0), .o_hreadyout(rdy0), .o_hresp(rsp0));

  ahb_lite_sram_slave #(.DATA_W(32), .ADDR_W(32), .DEPTH(1024), .WAIT_STATES(2), .BASE_ADDR(32'h0)) u1 (
    .i_hclk(clk), .i_hrst(rst), .i_hsel(sel[1]), .i_haddr(haddr), .i_htrans(htrans),
    .i_hsize(hsize), .i_hburst(hburst), .i_hwrite(hwrite), .i_hready(rdy1),
    .i_hwdata(hwdata[31:0]), .o_hrdata(rd1), .o_hreadyout(rdy1), .o_hresp(rsp1));

  ahb_lite_sram_slave #(.DATA_W(32), .ADDR_W(32), .DEPTH(1024), .WAIT_STATES(3), .BASE_ADDR(32'h0)) u2 (
    .i_hclk(clk), .i_hrst(rst), .i_hsel(sel[2]), .i_haddr(haddr), .i_htrans(htrans),
    .i_hsize(hsize), .i_hburst(hburst), .i_hwrite(hwrite), .i_hready(rdy2),
    .i_hwdata(hwdata[31:0]), .o_hrdata(rd2), .o_hreadyout(rdy2), .o_hresp(rsp2));

  ahb_lite_sram_slave #(.DATA_W(64), .ADDR_W(32), .DEPTH(16), .WAIT_STATES(0), .BASE_ADDR(32'h0)) u3 (
    .i_hclk(clk), .i_hrst(rst), .i_hsel(sel[3]), .i_haddr(haddr), .i_htrans(htrans),
    .i_hsize(hsize), .i_hburst(hburst), .i_hwrite(hwrite), .i_hready(rdy3),
    .i_hwdata(hwdata), .o_hrdata(rd3), .o_hreadyout(rdy3), .o_hresp(rsp3));

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic cyc;
    @(posedge clk);
    #1;
  endtask

  task automatic smp;
    @(negedge clk);
  endtask

  task automatic addr_ph(input int s, input logic [31:0] a, input logic [1:0] t,
                         input logic [2:0] sz, input logic w);
    sel    = 4'(1 << s);
    haddr  = a;
    htrans = t;
    hsize  = sz;
    hwrite = w;
  endtask

  task automatic bus_idle;
    sel    = 4'b0000;
    htrans = T_IDLE;
    hwrite = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    bus_idle();
    haddr  = '0;
    hsize  = 3'd0;
    hburst = 3'd0;
    hwdata = '0;

    // reset state
    repeat (3) @(posedge clk);
    smp();
    check("rst_rdy0",  64'(rdy0), 64'd1);
    check("rst_resp0", 64'(rsp0), 64'd0);
    check("rst_rdata0", 64'(rd0), 64'd0);
    check("rst_rdy3",  64'(rdy3), 64'd1);
    check("rst_rdata3", rd3,      64'd0);
    rst = 1'b0;

    // word write then pipelined read, zero wait
    cyc(); addr_ph(0, 32'h10, T_NONSEQ, 3'd2, 1'b1);
    cyc(); hwdata = 64'hDEADBEEF; addr_ph(0, 32'h10, T_NONSEQ, 3'd2, 1'b0);
    smp();
    check("t1_wr_rdy",   64'(rdy0), 64'd1);
    check("t1_wr_resp",  64'(rsp0), 64'd0);
    check("t1_wr_rdata", 64'(rd0),  64'd0);
    cyc(); bus_idle();
    smp();
    check("t1_rd_data", 64'(rd0),  64'hDEADBEEF);
    check("t1_rd_rdy",  64'(rdy0), 64'd1);
    check("t1_rd_resp", 64'(rsp0), 64'd0);

    // NONSEQ without hsel is not an access
    cyc(); sel = 4'b0000; htrans = T_NONSEQ; haddr = 32'h10; hwrite = 1'b0;
    cyc(); bus_idle();
    smp();
    check("nosel_rdata", 64'(rd0),  64'd0);
    check("nosel_rdy",   64'(rdy0), 64'd1);

    // byte and halfword lane writes
    cyc(); addr_ph(0, 32'h10, T_NONSEQ, 3'd2, 1'b1);
    cyc(); hwdata = 64'h0; addr_ph(0, 32'h13, T_NONSEQ, 3'd0, 1'b1);
    cyc(); hwdata = 64'hA5A5A5A5; addr_ph(0, 32'h10, T_NONSEQ, 3'd2, 1'b0);
    cyc(); bus_idle();
    smp();
    check("t2_byte", 64'(rd0), 64'hA5000000);
    cyc(); addr_ph(0, 32'h12, T_NONSEQ, 3'd1, 1'b1);
    cyc(); hwdata = 64'hBEEFCAFE; addr_ph(0, 32'h10, T_NONSEQ, 3'd2, 1'b0);
    cyc(); bus_idle();
    smp();
    check("t2_half", 64'(rd0), 64'hBEEF0000);

    // unaligned word read -> ERR1, ERR2, IDLE
    cyc(); addr_ph(0, 32'h2, T_NONSEQ, 3'd2, 1'b0);
    cyc(); bus_idle();
    smp();
    check("t4_err1_rdy",   64'(rdy0), 64'd0);
    check("t4_err1_resp",  64'(rsp0), 64'd1);
    check("t4_err1_rdata", 64'(rd0),  64'd0);
    cyc(); smp();
    check("t4_err2_rdy",  64'(rdy0), 64'd1);
    check("t4_err2_resp", 64'(rsp0), 64'd1);
    cyc(); smp();
    check("t4_idle_rdy",  64'(rdy0), 64'd1);
    check("t4_idle_resp", 64'(rsp0), 64'd0);

    // oversize write errors and is dropped; read accepted during ERR2
    cyc(); addr_ph(0, 32'h10, T_NONSEQ, 3'd3, 1'b1);
    cyc(); bus_idle(); hwdata = 64'hFFFFFFFF;
    smp();
    check("t4_size_resp", 64'(rsp0), 64'd1);
    cyc(); addr_ph(0, 32'h10, T_NONSEQ, 3'd2, 1'b0);
    cyc(); bus_idle();
    smp();
    check("t4_mem_kept", 64'(rd0),  64'hBEEF0000);
    check("t4_rd_resp",  64'(rsp0), 64'd0);

    // two wait states: write then read
    cyc(); addr_ph(1, 32'h20, T_NONSEQ, 3'd2, 1'b1);
    cyc(); bus_idle(); hwdata = 64'h12345678;
    smp(); check("t3w_w1", 64'(rdy1), 64'd0);
    cyc(); smp(); check("t3w_w2", 64'(rdy1), 64'd0);
    cyc(); smp(); check("t3w_done", 64'(rdy1), 64'd1);
    cyc(); addr_ph(1, 32'h20, T_NONSEQ, 3'd2, 1'b0);
    cyc(); bus_idle();
    smp();
    check("t3_w1_rdy",  64'(rdy1), 64'd0);
    check("t3_w1_resp", 64'(rsp1), 64'd0);
    cyc(); smp(); check("t3_w2_rdy", 64'(rdy1), 64'd0);
    cyc(); smp();
    check("t3_rdy",  64'(rdy1), 64'd1);
    check("t3_data", 64'(rd1),  64'h12345678);
    check("t3_resp", 64'(rsp1), 64'd0);
    cyc(); smp(); check("t3_after", 64'(rd1), 64'd0);

    // 64-bit, 16 words: INCR4 from 0x70 runs off the top at 0x80
    cyc(); addr_ph(3, 32'h0, T_NONSEQ, 3'd3, 1'b1);
    cyc(); hwdata = 64'h0123456789ABCDEF; hburst = 3'b011; addr_ph(3, 32'h70, T_NONSEQ, 3'd3, 1'b1);
    cyc(); hwdata = 64'h1111111111111111; addr_ph(3, 32'h78, T_SEQ, 3'd3, 1'b1);
    smp();
    check("t5_b0_rdy",  64'(rdy3), 64'd1);
    check("t5_b0_resp", 64'(rsp3), 64'd0);
    cyc(); hwdata = 64'h2222222222222222; addr_ph(3, 32'h80, T_SEQ, 3'd3, 1'b1);
    smp();
    check("t5_b1_rdy",  64'(rdy3), 64'd1);
    check("t5_b1_resp", 64'(rsp3), 64'd0);
    cyc(); hwdata = 64'hBADBADBADBADBAD0; bus_idle();
    smp();
    check("t5_b2_err1_rdy",  64'(rdy3), 64'd0);
    check("t5_b2_err1_resp", 64'(rsp3), 64'd1);
    cyc(); smp();
    check("t5_err2_rdy",  64'(rdy3), 64'd1);
    check("t5_err2_resp", 64'(rsp3), 64'd1);
    cyc(); hburst = 3'd0; addr_ph(3, 32'h0, T_NONSEQ, 3'd3, 1'b0);
    cyc(); addr_ph(3, 32'h70, T_NONSEQ, 3'd3, 1'b0);
    smp(); check("t5_word0_kept", rd3, 64'h0123456789ABCDEF);
    cyc(); addr_ph(3, 32'h78, T_NONSEQ, 3'd3, 1'b0);
    smp(); check("t5_rd70", rd3, 64'h1111111111111111);
    cyc(); addr_ph(3, 32'h7D, T_NONSEQ, 3'd0, 1'b1);
    smp(); check("t5_rd78", rd3, 64'h2222222222222222);
    cyc(); hwdata = 64'hFFFF5AFFFFFFFFFF; addr_ph(3, 32'h78, T_NONSEQ, 3'd3, 1'b0);
    cyc(); bus_idle();
    smp(); check("t5_byte5", rd3, 64'h22225A2222222222);

    // reset during a WS=3 write wait state drops the write
    cyc(); addr_ph(2, 32'h40, T_NONSEQ, 3'd2, 1'b1);
    cyc(); bus_idle(); hwdata = 64'hAAAA5555;
    repeat (3) cyc();
    smp(); check("t6_pre_rdy", 64'(rdy2), 64'd1);
    cyc(); addr_ph(2, 32'h40, T_NONSEQ, 3'd2, 1'b1);
    cyc(); bus_idle(); hwdata = 64'h0;
    smp(); check("t6_wait", 64'(rdy2), 64'd0);
    cyc(); rst = 1'b1;
    #1;
    check("t6_rst_rdy",   64'(rdy2), 64'd1);
    check("t6_rst_resp",  64'(rsp2), 64'd0);
    check("t6_rst_rdata", 64'(rd2),  64'd0);
    smp(); rst = 1'b0;
    cyc(); addr_ph(2, 32'h40, T_NONSEQ, 3'd2, 1'b0);
    cyc(); bus_idle();
    repeat (3) cyc();
    smp();
    check("t6_mem_kept", 64'(rd2),  64'hAAAA5555);
    check("t6_rd_rdy",   64'(rdy2), 64'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
